// File: rtl/reg_cmd_fsm.sv
// UART register-command engine: turns received byte frames into register
// writes/reads and streams read data back out through the UART transmitter.
module reg_cmd_fsm #(
   parameter int ADDR_BYTES  = 1,
   parameter int DATA_BYTES  = 2,
   parameter int TIMEOUT_CYC = 100000
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    rx_done_i,
   input  logic [7:0]              rx_data_i,
   input  logic                    tx_done_i,
   output logic                    tx_start_o,
   output logic [7:0]              tx_data_o,
   output logic [8*ADDR_BYTES-1:0] reg_addr_o,
   output logic [8*DATA_BYTES-1:0] reg_wdata_o,
   input  logic [8*DATA_BYTES-1:0] reg_rdata_i,
   output logic                    wr_en_o,
   output logic                    rd_en_o,
   output logic                    err_o,
   output logic                    busy_o
);

   localparam int AW = 8 * ADDR_BYTES;
   localparam int DW = 8 * DATA_BYTES;
   localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam int TMO_LAST = (TIMEOUT_CYC > 1) ? TIMEOUT_CYC - 2 : 0;
   localparam bit TMO_EN = (TIMEOUT_CYC > 0);
   localparam logic [TW-1:0] TMO_LAST_V = TW'(TMO_LAST);
   localparam logic [1:0] A_LAST = 2'(ADDR_BYTES - 1);
   localparam logic [1:0] D_LAST = 2'(DATA_BYTES - 1);

   localparam logic [7:0] CMD_NOP = 8'h00;
   localparam logic [7:0] CMD_WR  = 8'h01;
   localparam logic [7:0] CMD_RD  = 8'h02;

   typedef enum logic [2:0] {
      S_CMD,
      S_ADDR,
      S_DATA,
      S_RD_WAIT,
      S_TX,
      S_TX_WAIT
   } state_t;

   state_t          state_q, state_d;
   logic [1:0]      cnt_q, cnt_d;
   logic [TW-1:0]   tmo_q, tmo_d;
   logic            is_rd_q, is_rd_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [DW-1:0]   wdata_q, wdata_d;
   logic [DW-1:0]   rsh_q, rsh_d;
   logic [7:0]      txd_q, txd_d;
   logic            wr_q, wr_d;
   logic            rd_q, rd_d;
   logic            err_q, err_d;
   logic            txs_q, txs_d;
   logic            tmo_expired;

   // The timeout fires on the (TIMEOUT_CYC-1)th idle cycle so err_o rises TIMEOUT_CYC cycles after the last byte.
   assign tmo_expired = TMO_EN && (tmo_q == TMO_LAST_V);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tmo_d   = '0;
      is_rd_d = is_rd_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rsh_d   = rsh_q;
      txd_d   = txd_q;
      wr_d    = 1'b0;
      rd_d    = 1'b0;
      err_d   = 1'b0;
      txs_d   = 1'b0;

      case (state_q)
         S_CMD: begin
            if (rx_done_i) begin
               if (rx_data_i == CMD_WR || rx_data_i == CMD_RD) begin
                  is_rd_d = (rx_data_i == CMD_RD);
                  cnt_d   = '0;
                  state_d = S_ADDR;
               end else if (rx_data_i != CMD_NOP) begin
                  err_d = 1'b1;
               end
            end
         end

         S_ADDR: begin
            if (rx_done_i) begin
               addr_d = (addr_q << 8) | AW'(rx_data_i);
               if (cnt_q == A_LAST) begin
                  cnt_d = '0;
                  if (is_rd_q) begin
                     rd_d    = 1'b1;
                     state_d = S_RD_WAIT;
                  end else begin
                     state_d = S_DATA;
                  end
               end else begin
                  cnt_d = cnt_q + 2'd1;
               end
            end else if (tmo_expired) begin
               err_d   = 1'b1;
               state_d = S_CMD;
            end else begin
               tmo_d = TMO_EN ? tmo_q + TW'(1) : '0;
            end
         end

         S_DATA: begin
            if (rx_done_i) begin
               wdata_d = (wdata_q << 8) | DW'(rx_data_i);
               if (cnt_q == D_LAST) begin
                  cnt_d   = '0;
                  wr_d    = 1'b1;
                  state_d = S_CMD;
               end else begin
                  cnt_d = cnt_q + 2'd1;
               end
            end else if (tmo_expired) begin
               err_d   = 1'b1;
               state_d = S_CMD;
            end else begin
               tmo_d = TMO_EN ? tmo_q + TW'(1) : '0;
            end
         end

         // Read data is valid the cycle after the rd_en_o strobe, so wait for it to drop.
         S_RD_WAIT: begin
            if (!rd_q) begin
               rsh_d   = reg_rdata_i;
               cnt_d   = '0;
               state_d = S_TX;
            end
         end

         S_TX: begin
            txs_d   = 1'b1;
            txd_d   = rsh_q[DW-1 -: 8];
            state_d = S_TX_WAIT;
         end

         S_TX_WAIT: begin
            if (tx_done_i) begin
               rsh_d = rsh_q << 8;
               if (cnt_q == D_LAST) begin
                  cnt_d   = '0;
                  state_d = S_CMD;
               end else begin
                  cnt_d   = cnt_q + 2'd1;
                  state_d = S_TX;
               end
            end
         end

         default: state_d = S_CMD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_CMD;
         cnt_q   <= '0;
         tmo_q   <= '0;
         is_rd_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rsh_q   <= '0;
         txd_q   <= '0;
         wr_q    <= 1'b0;
         rd_q    <= 1'b0;
         err_q   <= 1'b0;
         txs_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tmo_q   <= tmo_d;
         is_rd_q <= is_rd_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rsh_q   <= rsh_d;
         txd_q   <= txd_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         err_q   <= err_d;
         txs_q   <= txs_d;
      end
   end

   assign tx_start_o  = txs_q;
   assign tx_data_o   = txd_q;
   assign reg_addr_o  = addr_q;
   assign reg_wdata_o = wdata_q;
   assign wr_en_o     = wr_q;
   assign rd_en_o     = rd_q;
   assign err_o       = err_q;
   assign busy_o      = (state_q != S_CMD);

endmodule

// File: tb/tb_reg_cmd_fsm.sv
// Bench for reg_cmd_fsm: a default-width instance (A) and a 2-addr/4-data
// instance (B), each with a UART TX responder and a registered read-data model.
module tb_reg_cmd_fsm;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;

   logic        rx_done_a, tx_done_a, tx_start_a, wr_a, rd_a, err_a, busy_a;
   logic [7:0]  rx_data_a, tx_data_a, addr_a;
   logic [15:0] wdata_a, rdata_a;
   logic        rvld_a;

   logic        rx_done_b, tx_done_b, tx_start_b, wr_b, rd_b, err_b, busy_b;
   logic [7:0]  rx_data_b, tx_data_b;
   logic [15:0] addr_b;
   logic [31:0] wdata_b, rdata_b;
   logic        rvld_b;

   reg_cmd_fsm #(.ADDR_BYTES(1), .DATA_BYTES(2), .TIMEOUT_CYC(16)) dut_a (
      .clk(clk), .rst_n(rst_n), .rx_done_i(rx_done_a), .rx_data_i(rx_data_a),
      .tx_done_i(tx_done_a), .tx_start_o(tx_start_a), .tx_data_o(tx_data_a),
      .reg_addr_o(addr_a), .reg_wdata_o(wdata_a), .reg_rdata_i(rdata_a),
      .wr_en_o(wr_a), .rd_en_o(rd_a), .err_o(err_a), .busy_o(busy_a));

   reg_cmd_fsm #(.ADDR_BYTES(2), .DATA_BYTES(4), .TIMEOUT_CYC(16)) dut_b (
      .clk(clk), .rst_n(rst_n), .rx_done_i(rx_done_b), .rx_data_i(rx_data_b),
      .tx_done_i(tx_done_b), .tx_start_o(tx_start_b), .tx_data_o(tx_data_b),
      .reg_addr_o(addr_b), .reg_wdata_o(wdata_b), .reg_rdata_i(rdata_b),
      .wr_en_o(wr_b), .rd_en_o(rd_b), .err_o(err_b), .busy_o(busy_b));

   // Register file answers one cycle after the read strobe; garbage otherwise.
   always @(posedge clk) begin
      rvld_a <= rd_a;
      rvld_b <= rd_b;
   end
   assign rdata_a = rvld_a ? 16'h1234 : 16'hDEAD;
   assign rdata_b = rvld_b ? 32'hCAFEF00D : 32'h0BAD0BAD;

   initial begin
      tx_done_a = 1'b0;
      forever begin
         @(negedge clk);
         if (tx_start_a) begin
            repeat (10) @(posedge clk);
            #1 tx_done_a = 1'b1;
            @(posedge clk);
            #1 tx_done_a = 1'b0;
         end
      end
   end

   initial begin
      tx_done_b = 1'b0;
      forever begin
         @(negedge clk);
         if (tx_start_b) begin
            repeat (10) @(posedge clk);
            #1 tx_done_b = 1'b1;
            @(posedge clk);
            #1 tx_done_b = 1'b0;
         end
      end
   end

   int cyc = 0;
   int wr_cnt_a = 0, rd_cnt_a = 0, err_cnt_a = 0, last_done_a = -1, fall_a = -1;
   int wr_cnt_b = 0, err_cnt_b = 0;
   int excl_viol = 0, stab_viol = 0;
   logic [7:0] txlog_a[$];
   logic [7:0] txlog_b[$];
   logic pbusy_a = 1'b0;
   logic [3:0] pstr_a = '0, pstr_b = '0;

   always @(negedge clk) begin
      cyc = cyc + 1;
      if (wr_a) wr_cnt_a = wr_cnt_a + 1;
      if (rd_a) rd_cnt_a = rd_cnt_a + 1;
      if (err_a) err_cnt_a = err_cnt_a + 1;
      if (wr_b) wr_cnt_b = wr_cnt_b + 1;
      if (err_b) err_cnt_b = err_cnt_b + 1;
      if (tx_start_a) txlog_a.push_back(tx_data_a);
      if (tx_start_b) txlog_b.push_back(tx_data_b);
      if (tx_done_a) begin
         last_done_a = cyc;
         if (txlog_a.size() > 0 && tx_data_a !== txlog_a[$]) stab_viol = stab_viol + 1;
      end
      if (tx_done_b && txlog_b.size() > 0 && tx_data_b !== txlog_b[$]) stab_viol = stab_viol + 1;
      if (pbusy_a && !busy_a) fall_a = cyc;
      pbusy_a = busy_a;
      if ($countones({wr_a, rd_a, err_a, tx_start_a}) > 1) excl_viol = excl_viol + 1;
      if ($countones({wr_b, rd_b, err_b, tx_start_b}) > 1) excl_viol = excl_viol + 1;
      if ((pstr_a & {wr_a, rd_a, err_a, tx_start_a}) != 4'b0) excl_viol = excl_viol + 1;
      if ((pstr_b & {wr_b, rd_b, err_b, tx_start_b}) != 4'b0) excl_viol = excl_viol + 1;
      pstr_a = {wr_a, rd_a, err_a, tx_start_a};
      pstr_b = {wr_b, rd_b, err_b, tx_start_b};
   end

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         failures = failures + 1;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send_a(input logic [7:0] b);
      @(posedge clk);
      #1 rx_done_a = 1'b1;
      rx_data_a = b;
      @(posedge clk);
      #1 rx_done_a = 1'b0;
   endtask

   task automatic send_b(input logic [7:0] b);
      @(posedge clk);
      #1 rx_done_b = 1'b1;
      rx_data_b = b;
      @(posedge clk);
      #1 rx_done_b = 1'b0;
   endtask

   typedef struct {
      int          n;
      logic [31:0] bytes;
      logic        exp_wr;
      logic        exp_err;
      logic [7:0]  exp_addr;
      logic [15:0] exp_wd;
   } vec_t;

   vec_t tbl[6];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w0, e0, r0, t0;
      rst_n = 1'b0;
      rx_done_a = 1'b0; rx_data_a = 8'h00;
      rx_done_b = 1'b0; rx_data_b = 8'h00;

      tbl[0] = '{4, 32'h0105ABCD, 1'b1, 1'b0, 8'h05, 16'hABCD};
      tbl[1] = '{1, 32'h00000000, 1'b0, 1'b0, 8'h05, 16'hABCD};
      tbl[2] = '{1, 32'h7F000000, 1'b0, 1'b1, 8'h05, 16'hABCD};
      tbl[3] = '{4, 32'h01010001, 1'b1, 1'b0, 8'h01, 16'h0001};
      tbl[4] = '{1, 32'hFF000000, 1'b0, 1'b1, 8'h01, 16'h0001};
      tbl[5] = '{4, 32'h01FE1234, 1'b1, 1'b0, 8'hFE, 16'h1234};

      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("reset_outs_a", {tx_start_a, tx_data_a, addr_a, wdata_a, wr_a, rd_a, err_a, busy_a}, 64'd0);
      chk("reset_outs_b", {tx_start_b, tx_data_b, addr_b, wdata_b, wr_b, rd_b, err_b, busy_b}, 64'd0);

      // Write / NOP / unknown-command frames
      for (int v = 0; v < 6; v++) begin
         w0 = wr_cnt_a; e0 = err_cnt_a;
         for (int i = 0; i < tbl[v].n; i++) send_a(tbl[v].bytes[31-8*i -: 8]);
         @(negedge clk);
         chk($sformatf("v%0d_wr", v), wr_a, tbl[v].exp_wr);
         chk($sformatf("v%0d_err", v), err_a, tbl[v].exp_err);
         chk($sformatf("v%0d_addr", v), addr_a, tbl[v].exp_addr);
         chk($sformatf("v%0d_wdata", v), wdata_a, tbl[v].exp_wd);
         chk($sformatf("v%0d_busy", v), busy_a, 1'b0);
         @(negedge clk);
         chk($sformatf("v%0d_wr_cnt", v), wr_cnt_a - w0, tbl[v].exp_wr);
         chk($sformatf("v%0d_err_cnt", v), err_cnt_a - e0, tbl[v].exp_err);
      end

      // Read with two-byte response
      r0 = rd_cnt_a; e0 = err_cnt_a; t0 = txlog_a.size();
      send_a(8'h02);
      send_a(8'h07);
      @(negedge clk);
      chk("rd_strobe", rd_a, 1'b1);
      chk("rd_addr", addr_a, 8'h07);
      for (int k = 0; k < 100 && busy_a; k++) @(negedge clk);
      chk("rd_busy_done", busy_a, 1'b0);
      @(negedge clk);
      chk("rd_cnt", rd_cnt_a - r0, 1);
      chk("rd_tx_n", txlog_a.size() - t0, 2);
      chk("rd_tx0", (txlog_a.size() > t0) ? txlog_a[t0] : 8'h00, 8'h12);
      chk("rd_tx1", (txlog_a.size() > t0 + 1) ? txlog_a[t0+1] : 8'h00, 8'h34);
      chk("rd_busy_fall", fall_a, last_done_a + 1);
      chk("rd_no_err", err_cnt_a - e0, 0);

      // Timeout: err 16 cycles after the last byte, no write
      w0 = wr_cnt_a;
      send_a(8'h01);
      send_a(8'h05);
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         chk($sformatf("tmo_err_c%0d", k), err_a, (k == 16));
      end
      chk("tmo_no_wr", wr_cnt_a - w0, 0);
      chk("tmo_idle", busy_a, 1'b0);

      // Byte on the expiry cycle wins; frame completes
      w0 = wr_cnt_a; e0 = err_cnt_a;
      send_a(8'h01);
      send_a(8'h05);
      repeat (13) @(posedge clk);
      send_a(8'h5A);
      send_a(8'hA5);
      @(negedge clk);
      chk("tmo_edge_wr", wr_a, 1'b1);
      chk("tmo_edge_wdata", wdata_a, 16'h5AA5);
      chk("tmo_edge_no_err", err_cnt_a - e0, 0);

      // Reset between the two response bytes
      send_a(8'h02);
      send_a(8'h07);
      for (int k = 0; k < 60 && !tx_done_a; k++) @(negedge clk);
      chk("rst_first_done", tx_done_a, 1'b1);
      @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_mid_outs", {tx_start_a, tx_data_a, addr_a, wdata_a, wr_a, rd_a, err_a, busy_a}, 64'd0);
      t0 = txlog_a.size();
      repeat (30) @(negedge clk);
      chk("rst_no_tx", txlog_a.size() - t0, 0);
      send_a(8'h01); send_a(8'h33); send_a(8'hBE); send_a(8'hEF);
      @(negedge clk);
      chk("rst_wr", wr_a, 1'b1);
      chk("rst_wr_addr", addr_a, 8'h33);
      chk("rst_wr_wdata", wdata_a, 16'hBEEF);

      // Wide instance: write, then read with a byte injected mid-response
      w0 = wr_cnt_b; e0 = err_cnt_b;
      send_b(8'h01); send_b(8'h12); send_b(8'h34);
      send_b(8'hDE); send_b(8'hAD); send_b(8'hBE); send_b(8'hEF);
      @(negedge clk);
      chk("b_wr", wr_b, 1'b1);
      chk("b_addr", addr_b, 16'h1234);
      chk("b_wdata", wdata_b, 32'hDEADBEEF);
      @(negedge clk);
      chk("b_wr_cnt", wr_cnt_b - w0, 1);
      t0 = txlog_b.size();
      send_b(8'h02); send_b(8'hAB); send_b(8'hCD);
      for (int k = 0; k < 20 && !tx_start_b; k++) @(negedge clk);
      chk("b_tx_started", tx_start_b, 1'b1);
      send_b(8'h01);
      for (int k = 0; k < 200 && busy_b; k++) @(negedge clk);
      chk("b_busy_done", busy_b, 1'b0);
      repeat (3) @(negedge clk);
      chk("b_tx_n", txlog_b.size() - t0, 4);
      chk("b_tx0", (txlog_b.size() > t0) ? txlog_b[t0] : 8'h00, 8'hCA);
      chk("b_tx1", (txlog_b.size() > t0 + 1) ? txlog_b[t0+1] : 8'h00, 8'hFE);
      chk("b_tx2", (txlog_b.size() > t0 + 2) ? txlog_b[t0+2] : 8'h00, 8'hF0);
      chk("b_tx3", (txlog_b.size() > t0 + 3) ? txlog_b[t0+3] : 8'h00, 8'h0D);
      chk("b_drop_idle", busy_b, 1'b0);
      chk("b_drop_no_wr", wr_cnt_b - w0, 1);
      chk("b_no_err", err_cnt_b - e0, 0);
      chk("b_rd_addr", addr_b, 16'hABCD);

      chk("strobe_exclusive", excl_viol, 0);
      chk("tx_data_stable", stab_viol, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
